// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer: one shared ALU and one unified memory port serve each instruction over several states.
// Optional macro PERF_CNT_EN adds cycle_cnt/retired_cnt performance counters.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        Regwrite,
    output logic [2:0]  ALUctrl,
    output logic        ALUsrc,
    output logic [1:0]  Immsrc,
    output logic [1:0]  PCsrc,
    output logic        MUX3Sel,
    output logic        Memwrite,
    output logic        jump_mux_sel,
    output logic        instr_done,
    output logic        bus_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_LOADWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R,
        C_LOAD,
        C_STORE,
        C_IALU,
        C_BRANCH,
        C_JUMP
    } iclass_t;

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    iclass_t       cls_d;
    iclass_t       cls_q;
    logic [2:0]    alu_d;
    logic [2:0]    alu_q;
    logic [CW-1:0] wait_cnt;
    logic          in_req;
    logic          timeout_hit;
    logic          unused_bits;

    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], instr[3], instr[1:0]};

    always_comb begin
        unique case (instr[6:4])
            3'b011:  cls_d = C_R;
            3'b000:  cls_d = C_LOAD;
            3'b010:  cls_d = C_STORE;
            3'b001:  cls_d = C_IALU;
            default: cls_d = instr[2] ? C_JUMP : C_BRANCH;
        endcase
    end

    always_comb begin
        unique case ({instr[14:12], instr[30]})
            4'b0000: alu_d = 3'b000;
            4'b0001: alu_d = 3'b001;
            4'b1110: alu_d = 3'b010;
            4'b1100: alu_d = 3'b011;
            4'b0100: alu_d = 3'b101;
            default: alu_d = 3'b000;
        endcase
    end

    assign in_req      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // The wait that brings the counter up to the limit is the last one tolerated.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_req && !mem_ready && (wait_cnt == LAST_WAIT);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cls_q <= C_R;
            alu_q <= 3'b000;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                cls_q <= cls_d;
                alu_q <= alu_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (in_req && !mem_ready) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (timeout_hit) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first; any output a state does not drive stays 0 and no latch is inferred.
        next_state   = state;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        Regwrite     = 1'b0;
        ALUctrl      = 3'b000;
        ALUsrc       = 1'b0;
        Immsrc       = 2'b00;
        PCsrc        = 2'b00;
        MUX3Sel      = 1'b0;
        Memwrite     = 1'b0;
        jump_mux_sel = 1'b0;
        instr_done   = 1'b0;
        // Reset blanks every strobe immediately, before any clock edge arrives.
        if (rst_n) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        next_state = S_DECODE;
                    end else if (timeout_hit) begin
                        next_state = S_HALT;
                    end
                end
                S_DECODE: begin
                    unique case (cls_d)
                        C_R, C_IALU:     next_state = S_EXEC;
                        C_LOAD, C_STORE: next_state = S_MEMADR;
                        C_BRANCH:        next_state = S_BRANCH;
                        default:         next_state = S_JUMP;
                    endcase
                end
                S_EXEC: begin
                    ALUsrc     = (cls_q == C_IALU);
                    Immsrc     = (cls_q == C_IALU) ? 2'b11 : 2'b00;
                    ALUctrl    = alu_q;
                    next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    ALUsrc     = (cls_q == C_IALU);
                    Immsrc     = (cls_q == C_IALU) ? 2'b11 : 2'b00;
                    ALUctrl    = alu_q;
                    Regwrite   = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMADR: begin
                    ALUsrc     = 1'b1;
                    Immsrc     = (cls_q == C_STORE) ? 2'b01 : 2'b00;
                    next_state = (cls_q == C_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    MUX3Sel      = 1'b1;
                    if (mem_ready) begin
                        next_state = S_LOADWB;
                    end else if (timeout_hit) begin
                        next_state = S_HALT;
                    end
                end
                S_LOADWB: begin
                    Regwrite   = 1'b1;
                    MUX3Sel    = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    Memwrite     = 1'b1;
                    Immsrc       = 2'b01;
                    ALUsrc       = 1'b1;
                    if (mem_ready) begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end else if (timeout_hit) begin
                        next_state = S_HALT;
                    end
                end
                S_BRANCH: begin
                    ALUctrl    = 3'b001;
                    Immsrc     = 2'b10;
                    PCsrc      = eq ? 2'b00 : 2'b01;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    ALUsrc       = 1'b1;
                    Regwrite     = 1'b1;
                    jump_mux_sel = 1'b1;
                    PCsrc        = 2'b10;
                    pc_we        = 1'b1;
                    instr_done   = 1'b1;
                    next_state   = S_FETCH;
                end
                S_HALT: begin
                    next_state = S_HALT;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            if (state != S_HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (instr_done) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`else
    // Without the counters there is nothing extra to build.
`endif

    a_memwrite_only_in_memwr : assert property (@(posedge clk) disable iff (!rst_n)
        Memwrite |-> (state == S_MEMWR));
    a_pc_we_retires : assert property (@(posedge clk) disable iff (!rst_n)
        pc_we |-> instr_done);
    a_halt_flags_error : assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_HALT) |-> bus_err);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: a per-cycle expected trace is built from the instruction rules.
// Build with PERF_CNT_EN defined to also check the performance counters.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic       regwrite;
        logic [2:0] aluctrl;
        logic       alusrc;
        logic [1:0] immsrc;
        logic [1:0] pcsrc;
        logic       mux3sel;
        logic       memwrite;
        logic       jump_mux_sel;
        logic       instr_done;
        logic       bus_err;
    } ctl_t;

    typedef enum int {K_R, K_LOAD, K_STORE, K_IALU, K_BRANCH, K_JUMP} kind_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr = '0;
    logic        eq = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_addr_sel, ir_we, pc_we, Regwrite;
    logic [2:0]  ALUctrl;
    logic        ALUsrc;
    logic [1:0]  Immsrc, PCsrc;
    logic        MUX3Sel, Memwrite, jump_mux_sel, instr_done, bus_err;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int    n_cmp = 0;
    int    n_bad = 0;
    int    mcyc  = 0;
    int    mret  = 0;
    int    cyc   = 0;
    string cur_tag = "";
    ctl_t  exp_q[$];
    logic  rdy_q[$];
    ctl_t  got;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .Regwrite(Regwrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .Immsrc(Immsrc),
        .PCsrc(PCsrc), .MUX3Sel(MUX3Sel), .Memwrite(Memwrite), .jump_mux_sel(jump_mux_sel),
        .instr_done(instr_done), .bus_err(bus_err)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    assign got = {mem_req, mem_addr_sel, ir_we, pc_we, Regwrite, ALUctrl, ALUsrc, Immsrc,
                  PCsrc, MUX3Sel, Memwrite, jump_mux_sel, instr_done, bus_err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, req);
        end
    endtask

    function automatic kind_t kind_of(input logic [31:0] ins);
        logic [2:0] op = ins[6:4];
        if (op == 3'b011) return K_R;
        if (op == 3'b000) return K_LOAD;
        if (op == 3'b010) return K_STORE;
        if (op == 3'b001) return K_IALU;
        return ins[2] ? K_JUMP : K_BRANCH;
    endfunction

    function automatic logic [2:0] alu_of(input logic [31:0] ins);
        logic [3:0] key = {ins[14:12], ins[30]};
        if (key == 4'b0000) return 3'b000;
        if (key == 4'b0001) return 3'b001;
        if (key == 4'b1110) return 3'b010;
        if (key == 4'b1100) return 3'b011;
        if (key == 4'b0100) return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic [31:0] gen(input kind_t k);
        logic [31:0] r = $urandom;
        case (k)
            K_R:      r[6:4] = 3'b011;
            K_LOAD:   r[6:4] = 3'b000;
            K_STORE:  r[6:4] = 3'b010;
            K_IALU:   r[6:4] = 3'b001;
            K_BRANCH: begin r[6] = 1'b1; r[2] = 1'b0; end
            default:  begin r[6] = 1'b1; r[2] = 1'b1; end
        endcase
        return r;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input ctl_t e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // Memory request: waits cycles without ready, then completion; at TO waits the bus errors out.
    task automatic req_phase(input ctl_t wait_v, input ctl_t done_v, input int waits, output bit timed_out);
        ctl_t halt_v = '0;
        halt_v.bus_err = 1'b1;
        timed_out = (waits >= TO);
        for (int i = 0; i < (timed_out ? TO : waits); i++) push(wait_v, 1'b0);
        if (timed_out) begin
            for (int i = 0; i < 3; i++) push(halt_v, rnd());
        end else begin
            push(done_v, 1'b1);
        end
    endtask

    task automatic plan(input logic [31:0] ins, input logic e, input int fw, input int dw);
        kind_t      k = kind_of(ins);
        logic [2:0] a = alu_of(ins);
        ctl_t       w, d, x;
        bit         to;
        w = '0; w.mem_req = 1'b1;
        d = w;  d.ir_we = 1'b1;
        req_phase(w, d, fw, to);
        if (to) return;
        push('0, rnd());
        x = '0;
        case (k)
            K_R, K_IALU: begin
                x.alusrc  = (k == K_IALU);
                x.immsrc  = (k == K_IALU) ? 2'b11 : 2'b00;
                x.aluctrl = a;
                push(x, rnd());
                x.regwrite = 1'b1; x.pc_we = 1'b1; x.instr_done = 1'b1;
                push(x, rnd());
            end
            K_LOAD: begin
                x.alusrc = 1'b1;
                push(x, rnd());
                w = '0; w.mem_req = 1'b1; w.mem_addr_sel = 1'b1; w.mux3sel = 1'b1;
                req_phase(w, w, dw, to);
                if (to) return;
                x = '0; x.regwrite = 1'b1; x.mux3sel = 1'b1; x.pc_we = 1'b1; x.instr_done = 1'b1;
                push(x, rnd());
            end
            K_STORE: begin
                x.alusrc = 1'b1; x.immsrc = 2'b01;
                push(x, rnd());
                w = '0; w.mem_req = 1'b1; w.mem_addr_sel = 1'b1; w.memwrite = 1'b1;
                w.immsrc = 2'b01; w.alusrc = 1'b1;
                d = w; d.pc_we = 1'b1; d.instr_done = 1'b1;
                req_phase(w, d, dw, to);
            end
            K_BRANCH: begin
                x.aluctrl = 3'b001; x.immsrc = 2'b10; x.pc_we = 1'b1; x.instr_done = 1'b1;
                x.pcsrc = e ? 2'b00 : 2'b01;
                push(x, rnd());
            end
            default: begin
                x.alusrc = 1'b1; x.regwrite = 1'b1; x.jump_mux_sel = 1'b1; x.pcsrc = 2'b10;
                x.pc_we = 1'b1; x.instr_done = 1'b1;
                push(x, rnd());
            end
        endcase
    endtask

    // Called at posedge+1; drives one cycle, samples at the falling edge, returns at next posedge+1.
    task automatic step_one();
        ctl_t e = exp_q.pop_front();
        mem_ready = rdy_q.pop_front();
        @(negedge clk);
        check($sformatf("%s.c%0d", cur_tag, cyc), {14'd0, got}, {14'd0, e});
`ifdef PERF_CNT_EN
        check($sformatf("%s.c%0d.cycle_cnt", cur_tag, cyc), cycle_cnt, 32'(mcyc));
        check($sformatf("%s.c%0d.retired_cnt", cur_tag, cyc), retired_cnt, 32'(mret));
`endif
        if (!e.bus_err) mcyc++;
        if (e.instr_done) mret++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input string tag, input logic [31:0] ins, input logic e, input int fw, input int dw);
        cur_tag = tag;
        cyc = 0;
        instr = ins;
        eq = e;
        plan(ins, e, fw, dw);
        while (exp_q.size() > 0) step_one();
    endtask

    task automatic reset_pulse(input string tag);
        exp_q.delete();
        rdy_q.delete();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check({tag, ".outs"}, {14'd0, got}, 32'd0);
`ifdef PERF_CNT_EN
        check({tag, ".cycle_cnt"}, cycle_cnt, 32'd0);
        check({tag, ".retired_cnt"}, retired_cnt, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        check({tag, ".hold"}, {14'd0, got}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mcyc = 0;
        mret = 0;
    endtask

    initial begin
        kind_t k;
        #2;
        reset_pulse("por");

        do_instr("add", 32'h00B50533, 1'b0, 0, 0);
        do_instr("load_w", 32'h00052583, 1'b0, 2, 1);
        do_instr("br_eq1", 32'h00000063, 1'b1, 0, 0);
        do_instr("br_eq0", 32'h00000063, 1'b0, 0, 0);
        do_instr("jal", 32'h008000EF, 1'b0, 0, 0);
        do_instr("sw", 32'h00B52223, 1'b0, 0, 0);
        do_instr("ialu_key1", 32'h40050513, 1'b0, 1, 0);
        do_instr("sw_edge", 32'h00B52223, 1'b0, TO - 1, TO - 1);
        do_instr("lw_edge", 32'h00052583, 1'b1, TO - 1, TO - 1);

        for (int i = 0; i < 40; i++) begin
            k = kind_t'($urandom_range(0, 5));
            do_instr($sformatf("rnd%0d", i), gen(k), rnd(), int'($urandom_range(0, TO - 1)),
                     int'($urandom_range(0, TO - 1)));
        end

        do_instr("sw_timeout", 32'h00B52223, 1'b0, 0, TO);
        reset_pulse("rst_halt");
        do_instr("lw_timeout", 32'h00052583, 1'b0, 1, TO);
        reset_pulse("rst_halt2");
        do_instr("fetch_timeout", 32'h00B50533, 1'b0, TO, 0);
        reset_pulse("rst_halt3");

        // Abort a store while it is still waiting in the write state.
        cur_tag = "sw_abort";
        cyc = 0;
        instr = 32'h00B52223;
        plan(instr, 1'b0, 0, TO - 1);
        for (int i = 0; i < 5; i++) step_one();
        reset_pulse("rst_memwr");
        do_instr("add_after", 32'h00B50533, 1'b0, 0, 0);
        do_instr("jal_after", 32'h008000EF, 1'b1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
